// File: rtl/pipelined_carry_adder_if.sv
// rtl/pipelined_carry_adder_if.sv - operand/result handshake bundle for pipelined_carry_adder
// The ovf signal exists only when RCA_PIPE_OVF_EN is defined.
interface pipelined_carry_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef RCA_PIPE_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
`endif
endinterface

// File: rtl/pipelined_carry_adder.sv
// rtl/pipelined_carry_adder.sv - WIDTH-bit adder split into SEG-bit ripple segments, one register stage each
// Optional signed-overflow output enabled by RCA_PIPE_OVF_EN.
module pipelined_carry_adder #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  pipelined_carry_adder_if.slave bus
);
  localparam int NSTG = WIDTH / SEG;

  if (WIDTH % SEG != 0) begin : g_bad_param
    $error("WIDTH must be a multiple of SEG");
  end

  function automatic logic [SEG:0] seg_add(
    input logic [SEG-1:0] x,
    input logic [SEG-1:0] y,
    input logic           ci
  );
    logic [SEG-1:0] s;
    logic           c;
    logic           p;
    logic           g;
    s = '0;
    c = ci;
    for (int i = 0; i < SEG; i++) begin
      p    = x[i] ^ y[i];
      g    = x[i] & y[i];
      s[i] = p ^ c;
      c    = g | (c & p);
    end
    return {c, s};
  endfunction

  logic [NSTG-1:0] v;
  logic [NSTG-1:0] adv;

  // A stage may load when it is empty or its occupant moves on this edge.
  always_comb begin
    logic go;
    adv = '0;
    go  = bus.out_ready;
    for (int s = NSTG - 1; s >= 0; s--) begin
      go     = ~v[s] | go;
      adv[s] = go;
    end
  end

  for (genvar s = 0; s < NSTG; s++) begin : stg
    localparam int LO = s * SEG;

    logic                v_q;
    logic                c_q;
    logic [LO+SEG-1:0]   sum_q;
    logic                src_v;
    logic                src_c;
    logic [WIDTH-LO-1:0] src_a;
    logic [WIDTH-LO-1:0] src_b;
    logic [LO+SEG-1:0]   sum_d;
    logic [SEG:0]        r;

    if (s == 0) begin : g_in
      assign src_v = bus.in_valid;
      assign src_c = bus.cin;
      assign src_a = bus.a;
      assign src_b = bus.b;
      assign sum_d = r[SEG-1:0];
    end else begin : g_chain
      assign src_v = stg[s-1].v_q;
      assign src_c = stg[s-1].c_q;
      assign src_a = stg[s-1].g_rem.a_q;
      assign src_b = stg[s-1].g_rem.b_q;
      assign sum_d = {r[SEG-1:0], stg[s-1].sum_q};
    end

    assign r    = seg_add(src_a[SEG-1:0], src_b[SEG-1:0], src_c);
    assign v[s] = v_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        sum_q <= '0;
      end else if (adv[s]) begin
        v_q <= src_v;
        if (src_v) begin
          c_q   <= r[SEG];
          sum_q <= sum_d;
        end
      end
    end

    // Operand bits above this segment ride along until their own stage.
    if (s < NSTG - 1) begin : g_rem
      logic [WIDTH-LO-SEG-1:0] a_q;
      logic [WIDTH-LO-SEG-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv[s] && src_v) begin
          a_q <= src_a[WIDTH-LO-1:SEG];
          b_q <= src_b[WIDTH-LO-1:SEG];
        end
      end
    end

`ifdef RCA_PIPE_OVF_EN
    // Carry into the MSB is P^S at that bit; overflow is that XOR the carry out.
    if (s == NSTG - 1) begin : g_ovf
      logic ovf_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv[s] && src_v) begin
          ovf_q <= src_a[SEG-1] ^ src_b[SEG-1] ^ r[SEG-1] ^ r[SEG];
        end
      end
    end
`endif
  end

  assign bus.in_ready  = adv[0];
  assign bus.out_valid = v[NSTG-1];
  assign bus.sum       = stg[NSTG-1].sum_q;
  assign bus.cout      = stg[NSTG-1].c_q;
`ifdef RCA_PIPE_OVF_EN
  assign bus.ovf       = stg[NSTG-1].g_ovf.ovf_q;
`endif

endmodule

// File: doc/pipelined_carry_adder.md
Name: pipelined_carry_adder

Overview:
- Parametrised, pipelined successor to the team's 4-bit combinational ripple-carry adder.
- Splits a WIDTH-bit add into WIDTH/SEG carry segments, one register stage per segment.
- Accepts one operand pair per cycle through a valid/ready handshake with full backpressure.
- Used wherever wide adds must close timing at the core clock.

Parameters:
- WIDTH, 16, operand/sum width in bits.
- SEG, 4, bits resolved per stage. WIDTH mod SEG must be 0.
- NSTG, WIDTH/SEG (derived localparam), number of pipeline stages.

Ports:
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous active-low reset
- IN_VALID  in  1  operand beat present
- IN_READY  out  1  block can accept a beat this cycle
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- CIN  in  1  carry-in to bit 0
- OUT_VALID  out  1  result beat present
- OUT_READY  in  1  consumer accepts result
- SUM  out  WIDTH  A+B+CIN modulo 2^WIDTH
- COUT  out  1  carry out of bit WIDTH-1
- OVF  out  1  signed overflow; present only with RCA_PIPE_OVF_EN

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous, active-low (RST_N). While RST_N=0, all stage valid bits are 0, so OUT_VALID=0. SUM, COUT and OVF read 0. IN_READY=1 from the first cycle after release.
- Stage s (s = 0..NSTG-1) holds:
  - a valid bit;
  - sum bits [(s+1)*SEG-1:0];
  - carry out of segment s;
  - the not-yet-added upper slices of A and B.
- Stage 0 loads SEG bits of A[SEG-1:0]+B[SEG-1:0]+CIN, computed combinationally at input.
- Stage s+1 adds slice s+1 using stage s's carry.
- Each segment is a ripple of per-bit P=A^B, G=A&B, C=G|(Cprev&P), S=P^Cprev.
- Handshake:
  - A beat transfers on any edge where VALID=1 and READY=1.
  - OUT_VALID and payload hold stable until OUT_READY=1.
  - IN_READY is combinational from stage state and OUT_READY, never from IN_VALID.
- Advance rule: stage s loads from stage s-1 (or the input for s=0) when stage s is empty or stage s is itself moving forward. Stage NSTG-1 moves when OUT_READY=1. Bubbles collapse, and no beat is dropped or duplicated.
- Latency:
  - A beat accepted on edge e is visible on SUM/COUT with OUT_VALID=1 after edge e+NSTG-1 if the pipeline is unstalled. That is NSTG cycles, counting the accepting edge.
  - Throughput is 1 beat/cycle with OUT_READY held 1.
- Full: all NSTG stages valid and OUT_READY=0 gives IN_READY=0. The pipeline holds every stage unchanged.
- Simultaneous events: when full and OUT_READY=1 in the same cycle, IN_READY=1. Output retire and input accept both occur on that edge.
- Empty: OUT_VALID=0 and SUM/COUT hold their last value; they are don't-care for checkers.
- Wrap-around: the sum is modulo 2^WIDTH, and COUT carries the lost bit.
- Reset mid-operation: in-flight beats are discarded and outputs immediately take reset values. No partial result is emitted after release.
- Ordering: results leave in acceptance order.

Optional Feature:
- Macro: RCA_PIPE_OVF_EN.
- Defined:
  - Port OVF exists and travels with its beat.
  - OVF = carry into bit WIDTH-1 XOR COUT, i.e. the sign of A equals the sign of B and differs from the sign of SUM.
  - OVF resets to 0.
- Undefined: the OVF port and its pipeline bit are absent; all other behaviour is identical.

Test Plan:
- Worst-case carry (WIDTH=16, SEG=4): A=0xFFFF, B=0x0001, CIN=0, single beat, OUT_READY=1. Required: SUM=0x0000, COUT=1, OUT_VALID=1 for exactly 1 cycle, 4 cycles after acceptance.
- Streaming: 8 back-to-back beats {A=i*0x1111, B=0x0F0F, CIN=i&1}, OUT_READY=1. Required: 8 consecutive OUT_VALID cycles, results in order, each matching the reference sum, and IN_READY constantly 1.
- Backpressure: stream 6 beats with OUT_READY=0 for cycles 3-10. Required:
  - IN_READY drops to 0 once 4 beats are held;
  - output payload stays stable while stalled;
  - all 6 results appear in order after release, with no loss or duplication.
- Full + simultaneous: pipeline full, then raise OUT_READY with IN_VALID=1. Required: one retire and one accept on the same edge, and occupancy stays 4.
- Reset mid-flight: assert RST_N=0 for 1 cycle while 3 beats are in flight. Required: OUT_VALID=0 immediately, no stale result afterwards, and a next beat 0x1234+0x4321 gives 0x5555, COUT=0.
- Overflow (with RCA_PIPE_OVF_EN): 0x7FFF+0x0001 gives SUM=0x8000, OVF=1, COUT=0. 0x8000+0x8000 gives SUM=0x0000, OVF=1, COUT=1. 0xFFFF+0x0001 gives OVF=0.
